gate_sensor_fsm: RTL
====================

# gate_sensor_fsm

Upstream front end of the parking-lot occupancy counter. Takes the two raw, asynchronous photo-sensor inputs at the gate (outer sensor A, inner sensor B). It synchronizes and debounces them, then tracks the A/B sequence of a passing car. It emits single-cycle `inc` (car entered) and `dec` (car exited) pulses that drive the occupancy counter's `inc`/`dec` inputs directly.

## Interface
- `DEBOUNCE`, default 4: consecutive cycles a synchronized input must hold a new value before the filtered value changes. Legal range is ≥1.
- `clk`  in  1  system clock. Reset is `reset`, synchronous, active-high; clock is `clk`.
- `reset`  in  1  synchronous, active-high reset.
- `sensor_a`  in  1  raw outer sensor, 1 = beam blocked, asynchronous.
- `sensor_b`  in  1  raw inner sensor, 1 = beam blocked, asynchronous.
- `inc`  out  1  one-cycle pulse: entry sequence completed.
- `dec`  out  1  one-cycle pulse: exit sequence completed.
- `fault`  out  1  one-cycle pulse: illegal sensor transition detected.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- **Synchronization:** each raw input passes through a two-flop synchronizer.
- **Debounce:** one counter per input.
  - While the synchronized value equals the filtered value, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - On the edge where the count would reach DEBOUNCE, the filtered value takes the new value and the counter clears.
  - A bounce back to the old value before that edge clears the counter. No filtered change occurs.
- **FSM input:** the filtered pair {a,b}.
- **States:** IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLEAR.
- **Entry path:** IDLE -10-> EN1 -11-> EN2 -01-> EN3 -00-> IDLE, with `inc` pulsed.
- **Exit path:** IDLE -01-> EX1 -11-> EX2 -10-> EX3 -00-> IDLE, with `dec` pulsed.
- **Backing up:** reversal by one step is legal and produces no pulse.
  - EN3 -11-> EN2, EN2 -10-> EN1, EN1 -00-> IDLE.
  - Exit path mirrors this: EX3 -11-> EX2, EX2 -01-> EX1, EX1 -00-> IDLE.
- **Illegal transition:** both filtered bits change in the same cycle, e.g. EN2 seeing 00, IDLE seeing 11, EN1 seeing 01.
  - `fault` pulses.
  - Next state is IDLE if the new value is 00, otherwise WAIT_CLEAR.
- **WAIT_CLEAR:** stays until the filtered value is 00, then goes to IDLE. No further faults and no pulses while in this state.
- **Unchanged input:** the FSM holds its state.
- **Exclusivity:** `inc`, `dec` and `fault` are mutually exclusive by construction. At most one is asserted in any cycle.
- **`busy`:** equals (state != IDLE), registered with the state.

## Timing
- **Reset:**
  - Synchronizer flops, filtered values and debounce counters are cleared to 0.
  - State goes to IDLE.
  - `inc` = `dec` = `fault` = `busy` = 0 on the first edge with `reset` high.
- **Reset mid-sequence:** the partial car is discarded and no pulse is emitted. After reset deasserts, the FSM starts from IDLE with filter = 0. Any blocked sensor then appears as a fresh edge.
- **Outputs:** all outputs are registered.
  - A pulse is high for exactly one cycle, on the edge where the FSM takes the completing transition.
  - Edge convention: edge 1 is the first rising edge to sample the new raw value.
  - The FSM registers the result on edge DEBOUNCE+3.
  - Example: with DEBOUNCE = 4, raw A/B reaching the final 00 → `inc` is high after edge 7.
- **Minimum spacing between cars:** the per-step filter delay. Back-to-back cars are separated only by the required 00 visit in IDLE, which may last a single filtered cycle.

## Structure
- **Package `parking_pkg`:**
  - `gate_state_t` enum, holding the eight states.
  - `DEBOUNCE_DEFAULT` = 4.
  - `sensor_pair_t` 2-bit typedef, {a,b}.
- **Sub-module `sensor_filter`:**
  - Contents: 2-flop synchronizer plus debounce counter, parameter DEBOUNCE, width $clog2(DEBOUNCE+1).
  - Instantiated once per sensor.
- **Top-level contents:** two filter instances, the FSM, and output registers.

## Test plan
All scenarios use DEBOUNCE = 4 unless noted.

1. Reset with sensors 00 → all outputs 0 and `busy` = 0. Raw 10,11,01,00, each held 10 cycles → exactly one `inc`, high after edge 7 of the final 00; `dec` stays 0.
2. Exit sequence 01,11,10,00, each held 10 cycles → exactly one `dec` pulse and no `inc`. Feeding `inc`/`dec` into the occupancy counter leaves it back at 0 after one entry plus one exit.
3. Bounce: A toggled 1,0,1 with 2-cycle widths, then held 1 → filtered A changes only after the hold. Then 00 → no pulse, FSM back in IDLE.
4. Back-out: 10,11,10,00 → no `inc`, no `fault`; `busy` is 1 during the sequence and 0 at the end.
5. Illegal jump: 10 then 01 (both bits flip within one cycle at the raw inputs) → one `fault`, FSM in WAIT_CLEAR. Then 11 → no output. Then 00 → IDLE.
6. `reset` asserted while in EN3 → no `inc` on the following 00. With DEBOUNCE = 1, a full entry gives `inc` after edge 4 of the final 00.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types for the parking-gate front end: FSM states, sensor pair and
// the per-cycle transition function used by the gate sequencer.
package parking_pkg;

    localparam int DEBOUNCE_DEFAULT = 4;

    typedef logic [1:0] sensor_pair_t;  // {a, b}

    typedef enum logic [2:0] {
        IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLEAR
    } gate_state_t;

    typedef struct packed {
        gate_state_t nxt;
        logic        inc;
        logic        dec;
        logic        fault;
    } gate_step_t;

    // Every tracking state implies one filtered pair, so a two-bit jump away
    // from that pair is exactly the illegal case; one-bit moves are listed.
    function automatic gate_step_t gate_step(input gate_state_t s, input sensor_pair_t ab);
        gate_step_t r;
        r.nxt   = s;
        r.inc   = 1'b0;
        r.dec   = 1'b0;
        r.fault = 1'b0;
        case (s)
            IDLE: case (ab)
                2'b10:   r.nxt = EN1;
                2'b01:   r.nxt = EX1;
                2'b11:   begin r.fault = 1'b1; r.nxt = WAIT_CLEAR; end
                default: ;
            endcase
            EN1: case (ab)
                2'b00:   r.nxt = IDLE;
                2'b11:   r.nxt = EN2;
                2'b01:   begin r.fault = 1'b1; r.nxt = WAIT_CLEAR; end
                default: ;
            endcase
            EN2: case (ab)
                2'b10:   r.nxt = EN1;
                2'b01:   r.nxt = EN3;
                2'b00:   begin r.fault = 1'b1; r.nxt = IDLE; end
                default: ;
            endcase
            EN3: case (ab)
                2'b00:   begin r.inc = 1'b1; r.nxt = IDLE; end
                2'b11:   r.nxt = EN2;
                2'b10:   begin r.fault = 1'b1; r.nxt = WAIT_CLEAR; end
                default: ;
            endcase
            EX1: case (ab)
                2'b00:   r.nxt = IDLE;
                2'b11:   r.nxt = EX2;
                2'b10:   begin r.fault = 1'b1; r.nxt = WAIT_CLEAR; end
                default: ;
            endcase
            EX2: case (ab)
                2'b01:   r.nxt = EX1;
                2'b10:   r.nxt = EX3;
                2'b00:   begin r.fault = 1'b1; r.nxt = IDLE; end
                default: ;
            endcase
            EX3: case (ab)
                2'b00:   begin r.dec = 1'b1; r.nxt = IDLE; end
                2'b11:   r.nxt = EX2;
                2'b01:   begin r.fault = 1'b1; r.nxt = WAIT_CLEAR; end
                default: ;
            endcase
            WAIT_CLEAR: if (ab == 2'b00) r.nxt = IDLE;
            default: r.nxt = IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_sensor_fsm_if.sv
// Gate front-end bus: raw photo-sensor inputs in, occupancy pulses out.
interface gate_sensor_fsm_if;
    logic sensor_a;
    logic sensor_b;
    logic inc;
    logic dec;
    logic fault;
    logic busy;

    modport master (output sensor_a, sensor_b, input inc, dec, fault, busy);
    modport slave  (input sensor_a, sensor_b, output inc, dec, fault, busy);
endinterface

// File: rtl/sensor_filter.sv
// Two-flop synchronizer followed by a debounce counter for one raw sensor.
module sensor_filter #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The filtered value flips on the edge where the run of differing
    // samples would reach DEBOUNCE; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            filtered <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == filtered) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                filtered <= sync2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/gate_sensor_fsm.sv
// Parking-gate front end: filters sensors A/B and tracks the car's A/B
// sequence, emitting registered inc/dec/fault pulses and a busy flag.
module gate_sensor_fsm
    import parking_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    gate_sensor_fsm_if.slave bus
);
    logic        filt_a;
    logic        filt_b;
    gate_state_t state;
    gate_step_t  step;
    logic        inc;
    logic        dec;
    logic        fault;
    logic        busy;

    sensor_filter #(.DEBOUNCE(DEBOUNCE)) u_filt_a (
        .clk      (clk),
        .reset    (reset),
        .raw      (bus.sensor_a),
        .filtered (filt_a)
    );

    sensor_filter #(.DEBOUNCE(DEBOUNCE)) u_filt_b (
        .clk      (clk),
        .reset    (reset),
        .raw      (bus.sensor_b),
        .filtered (filt_b)
    );

    assign step = gate_step(state, {filt_a, filt_b});

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            inc   <= 1'b0;
            dec   <= 1'b0;
            fault <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= step.nxt;
            inc   <= step.inc;
            dec   <= step.dec;
            fault <= step.fault;
            busy  <= (step.nxt != IDLE);
        end
    end

    assign bus.inc   = inc;
    assign bus.dec   = dec;
    assign bus.fault = fault;
    assign bus.busy  = busy;
endmodule
